// File: rtl/life_gen_engine_pkg.sv
// Shared definitions for the Game-of-Life generation engine.
//   - default grid address width per axis
//   - FSM state encoding
//   - 3x3 neighbour offset table, row-major from (-1,-1) to (+1,+1)
//   - index of the centre cell within that table
package life_gen_engine_pkg;

  localparam int DEFAULT_K = 7;

  localparam logic [3:0] NB_CENTRE = 4'd4;
  localparam logic [3:0] NB_LAST   = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_DRAIN  = 3'd2,
    S_WRITE  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  // Two's-complement 2-bit offsets: -1, 0, +1.
  localparam logic [1:0] OFF_NEG  = 2'b11;
  localparam logic [1:0] OFF_ZERO = 2'b00;
  localparam logic [1:0] OFF_POS  = 2'b01;

  typedef struct packed {
    logic [1:0] dr;
    logic [1:0] dc;
  } nb_offset_t;

  localparam nb_offset_t NB_OFFSETS [9] = '{
    '{dr: OFF_NEG,  dc: OFF_NEG},
    '{dr: OFF_NEG,  dc: OFF_ZERO},
    '{dr: OFF_NEG,  dc: OFF_POS},
    '{dr: OFF_ZERO, dc: OFF_NEG},
    '{dr: OFF_ZERO, dc: OFF_ZERO},
    '{dr: OFF_ZERO, dc: OFF_POS},
    '{dr: OFF_POS,  dc: OFF_NEG},
    '{dr: OFF_POS,  dc: OFF_ZERO},
    '{dr: OFF_POS,  dc: OFF_POS}
  };

  // Out-of-table indices never occur in READ; return the centre offset so
  // the lookup is total.
  function automatic nb_offset_t nb_offset(input logic [3:0] nb);
    return (nb <= NB_LAST) ? NB_OFFSETS[nb] : NB_OFFSETS[NB_CENTRE];
  endfunction

endpackage

// File: rtl/life_gen_engine_rule.sv
// Conway's rule for a single cell.
// Ports:
//   alive      in  1  current state of the cell
//   n          in  4  number of live neighbours (0..8)
//   next_state out 1  state of the cell in the next generation
module life_gen_engine_rule (
  input  logic       alive,
  input  logic [3:0] n,
  output logic       next_state
);

  // Birth on exactly three neighbours, survival on two or three.
  assign next_state = (n == 4'd3) | (alive & (n == 4'd2));

endmodule

// File: rtl/life_gen_engine.sv
// Game-of-Life generation engine. On an accepted start it sweeps every cell
// of the 2^K x 2^K grid in the order supplied by an external address
// walkthrough: 9 neighbourhood reads, one drain cycle for the last read's
// data, one write of the next state. A done pulse marks the end of the sweep.
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   start              request a generation (honoured only while idle)
//   busy, done         engine active / generation complete pulse
//   gen_count          completed generations, wraps at 16 bits
//   walk_en            advance the walkthrough to the next cell
//   walk_r, walk_c     current cell from the walkthrough
//   walk_done          walkthrough is at its last cell
//   rd_r, rd_c         read address to the current-generation memory
//   rd_data            read data, one cycle after the address
//   wr_en, wr_r, wr_c  write strobe and address to the next-generation buffer
//   wr_data            next state of the cell being written
module life_gen_engine
  import life_gen_engine_pkg::*;
#(
  parameter int K    = DEFAULT_K,
  parameter bit WRAP = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [15:0]  gen_count,
  output logic         walk_en,
  input  logic [K-1:0] walk_r,
  input  logic [K-1:0] walk_c,
  input  logic         walk_done,
  output logic [K-1:0] rd_r,
  output logic [K-1:0] rd_c,
  input  logic         rd_data,
  output logic         wr_en,
  output logic [K-1:0] wr_r,
  output logic [K-1:0] wr_c,
  output logic         wr_data
);

  state_t      state;
  logic [3:0]  nb;
  logic [3:0]  n;
  logic        alive;

  // Tag travelling alongside each outstanding read: the datum arriving next
  // cycle is either the centre cell or a neighbour, and may be masked.
  logic        pend_valid;
  logic        pend_centre;
  logic        pend_live;

  logic [15:0] gen_count_q;
  logic        done_q;
  logic        wr_en_q;
  logic        walk_en_q;

  nb_offset_t  off;
  logic [K-1:0] off_r;
  logic [K-1:0] off_c;
  logic        row_edge;
  logic        col_edge;
  logic        in_range;
  logic        datum;

  assign off = nb_offset(nb);

  // Sign-extend the 2-bit offsets; K-bit addition then wraps modulo 2^K.
  assign off_r = {{(K-1){off.dr[1]}}, off.dr[0]};
  assign off_c = {{(K-1){off.dc[1]}}, off.dc[0]};

  assign row_edge = ((off.dr == OFF_NEG) && (walk_r == '0)) ||
                    ((off.dr == OFF_POS) && (walk_r == '1));
  assign col_edge = ((off.dc == OFF_NEG) && (walk_c == '0)) ||
                    ((off.dc == OFF_POS) && (walk_c == '1));

  // Without wrap the read is still issued (keeps timing fixed), but its
  // data is discarded when the neighbour lies off the grid.
  assign in_range = WRAP ? 1'b1 : !(row_edge || col_edge);

  assign rd_r = (state == S_READ) ? walk_r + off_r : '0;
  assign rd_c = (state == S_READ) ? walk_c + off_c : '0;

  assign datum = rd_data & pend_live;

  assign busy      = (state != S_IDLE);
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign walk_en   = walk_en_q;
  assign gen_count = gen_count_q;
  assign wr_r      = walk_r;
  assign wr_c      = walk_c;

  life_gen_engine_rule u_rule (
    .alive      (alive),
    .n          (n),
    .next_state (wr_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      nb          <= '0;
      n           <= '0;
      alive       <= 1'b0;
      pend_valid  <= 1'b0;
      pend_centre <= 1'b0;
      pend_live   <= 1'b0;
      gen_count_q <= '0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      walk_en_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below
      // sees the register values from the start of the cycle and later
      // assignments to the same register simply take priority.
      pend_valid <= 1'b0;

      // Consume the datum returned for the read issued last cycle.
      if (pend_valid) begin
        if (pend_centre) begin
          alive <= rd_data;
        end else begin
          n <= n + {3'b000, datum};
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_READ;
            nb    <= '0;
            n     <= '0;
          end
        end

        S_READ: begin
          pend_valid  <= 1'b1;
          pend_centre <= (nb == NB_CENTRE);
          pend_live   <= in_range;
          if (nb == NB_LAST) begin
            state <= S_DRAIN;
          end else begin
            nb <= nb + 4'd1;
          end
        end

        // The ninth datum is accumulated by the pend_valid logic above;
        // the strobes are registered so they are high exactly in WRITE.
        S_DRAIN: begin
          state     <= S_WRITE;
          wr_en_q   <= 1'b1;
          walk_en_q <= 1'b1;
        end

        S_WRITE: begin
          wr_en_q   <= 1'b0;
          walk_en_q <= 1'b0;
          nb        <= '0;
          if (walk_done) begin
            state  <= S_FINISH;
            done_q <= 1'b1;
          end else begin
            state <= S_READ;
            n     <= '0;
          end
        end

        S_FINISH: begin
          done_q      <= 1'b0;
          gen_count_q <= gen_count_q + 16'd1;
          state       <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_gen_engine.sv
// Bench for life_gen_engine on an 8x8 grid. Two engines run side by side on
// the same current-generation memory: index 0 with toroidal edges, index 1
// with dead edges. The bench supplies the walkthrough counter, the read
// memory and the next-generation buffer, and predicts each generation with
// a direct neighbour-counting model.
module tb_life_gen_engine;

  localparam int K     = 3;
  localparam int N     = 8;
  localparam int CELLS = 64;
  localparam int GEN_CYCLES = 705;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  wire  [1:0]   busy, done, walk_en, wr_en, wr_data, walk_done;
  wire  [15:0]  gen_count [2];
  wire  [K-1:0] walk_r [2], walk_c [2], rd_r [2], rd_c [2], wr_r [2], wr_c [2];
  logic [1:0]   rd_data;
  logic [2*K-1:0] walk_pos [2];

  bit   [63:0] cur;
  bit   [63:0] nxt [2];
  bit   [63:0] exp_grid [2];

  logic [5:0]  wr_idx [2];
  int          wr_cnt [2];
  int          walk_seen [2];
  int          done_seen [2];

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    life_gen_engine #(.K(K), .WRAP(gi == 0)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy[gi]),
      .done      (done[gi]),
      .gen_count (gen_count[gi]),
      .walk_en   (walk_en[gi]),
      .walk_r    (walk_r[gi]),
      .walk_c    (walk_c[gi]),
      .walk_done (walk_done[gi]),
      .rd_r      (rd_r[gi]),
      .rd_c      (rd_c[gi]),
      .rd_data   (rd_data[gi]),
      .wr_en     (wr_en[gi]),
      .wr_r      (wr_r[gi]),
      .wr_c      (wr_c[gi]),
      .wr_data   (wr_data[gi])
    );
    assign walk_r[gi]    = walk_pos[gi][2*K-1:K];
    assign walk_c[gi]    = walk_pos[gi][K-1:0];
    assign walk_done[gi] = &walk_pos[gi];
  end

  // Environment: walkthrough counter, 1-cycle read memory, write buffer.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      rd_data[i] <= cur[{rd_r[i], rd_c[i]}];
      if (rst) walk_pos[i] <= '0;
      else if (walk_en[i]) walk_pos[i] <= walk_pos[i] + 1'b1;
      if (wr_en[i]) nxt[i][{wr_r[i], wr_c[i]}] <= wr_data[i];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
  endtask

  // Next generation straight from the rules of the game.
  function automatic bit [63:0] next_grid(input bit [63:0] g, input bit wrap);
    bit [63:0] res;
    int cnt, rr, cc;
    res = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr == 0 && dc == 0) continue;
            rr = r + dr;
            cc = c + dc;
            if (wrap) begin
              rr = (rr + N) % N;
              cc = (cc + N) % N;
            end else if (rr < 0 || rr >= N || cc < 0 || cc >= N) begin
              continue;
            end
            cnt += int'(g[rr*N + cc]);
          end
        end
        res[r*N + c] = (cnt == 3) || (g[r*N + c] && cnt == 2);
      end
    end
    return res;
  endfunction

  // Compare process: every write must hit the next cell in sweep order
  // with the state the model predicts.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        wr_idx[i] <= '0;
      end else begin
        if (wr_en[i]) begin
          check($sformatf("wr_addr[%0d]", i), 64'({wr_r[i], wr_c[i]}), 64'(wr_idx[i]));
          check($sformatf("wr_data[%0d] cell %0d", i, wr_idx[i]),
                64'(wr_data[i]), 64'(exp_grid[i][wr_idx[i]]));
          check($sformatf("walk_en_with_wr[%0d]", i), 64'(walk_en[i]), 64'd1);
          wr_idx[i] <= wr_idx[i] + 1'b1;
          wr_cnt[i] <= wr_cnt[i] + 1;
        end
        if (walk_en[i]) walk_seen[i] <= walk_seen[i] + 1;
        if (done[i])    done_seen[i] <= done_seen[i] + 1;
      end
    end
  end

  function automatic int idx(input int r, input int c);
    return r*N + c;
  endfunction

  task automatic predict();
    exp_grid[0] = next_grid(cur, 1'b1);
    exp_grid[1] = next_grid(cur, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start, wait (bounded) for both engines' done, check the latency.
  // With extra_starts, start is re-pulsed while busy, incl. the FINISH cycle.
  task automatic run_gen(input bit extra_starts);
    int k;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1;
    check("busy_after_start", 64'(busy), 64'd3);
    while (k < 2000) begin
      start = extra_starts && (k == 1 || k == 50 || k == 704 || k == 705);
      if (done[0] && done[1]) break;
      @(negedge clk);
      k++;
    end
    check("cycles_to_done", 64'(k), 64'(GEN_CYCLES));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_grids(input string tag);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s grid[%0d]", tag, i), nxt[i], exp_grid[i]);
  endtask

  task automatic check_count(input string tag, input logic [15:0] want);
    for (int i = 0; i < 2; i++)
      check($sformatf("%s gen_count[%0d]", tag, i), 64'(gen_count[i]), 64'(want));
  endtask

  initial begin
    int snap_wr, snap_done, snap_walk;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst wr_en", 64'(wr_en), 64'd0);
    check("rst walk_en", 64'(walk_en), 64'd0);
    check_count("rst", 16'd0);
    check("rst rd_addr", 64'({rd_r[0], rd_c[0], rd_r[1], rd_c[1]}), 64'd0);
    rst = 1'b0;

    // Blinker: horizontal at row 3 turns vertical at column 3
    cur = '0;
    cur[idx(3,2)] = 1'b1; cur[idx(3,3)] = 1'b1; cur[idx(3,4)] = 1'b1;
    predict();
    check("model blinker wrap", exp_grid[0], 64'h0000_0008_0808_0000);
    check("model blinker nowrap", exp_grid[1], 64'h0000_0008_0808_0000);
    run_gen(1'b0);
    check_grids("blinker");
    check_count("blinker", 16'd1);
    check("idle busy", 64'(busy), 64'd0);

    // Still life block over three generations, swapping buffers each time
    do_reset();
    cur = 64'h0000_0018_1800_0000;
    for (int g = 0; g < 3; g++) begin
      predict();
      check("model block", exp_grid[0], 64'h0000_0018_1800_0000);
      run_gen(1'b0);
      check_grids($sformatf("block gen%0d", g));
      cur = nxt[0];
    end
    check_count("block", 16'd3);

    // Corner wrap: (7,7) born only with toroidal edges
    cur = 64'h0100_0000_0000_0081;
    predict();
    check("model corner wrap (7,7)", 64'(exp_grid[0][63]), 64'd1);
    check("model corner nowrap (0,0)", 64'(exp_grid[1][0]), 64'd0);
    run_gen(1'b0);
    check_grids("corner");
    check("corner wrap (7,7)", 64'(nxt[0][63]), 64'd1);
    check("corner nowrap (7,7)", 64'(nxt[1][63]), 64'd0);
    check("corner nowrap (0,0)", 64'(nxt[1][0]), 64'd0);
    check_count("corner", 16'd4);

    // Reset mid-generation
    cur = '0;
    cur[idx(3,2)] = 1'b1; cur[idx(3,3)] = 1'b1; cur[idx(3,4)] = 1'b1;
    predict();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (299) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", 64'(busy), 64'd0);
    check_count("midrst", 16'd0);
    snap_wr = wr_cnt[0] + wr_cnt[1];
    repeat (30) @(negedge clk);
    check("midrst no writes", 64'(wr_cnt[0] + wr_cnt[1]), 64'(snap_wr));
    run_gen(1'b0);
    check_grids("after midrst");
    check_count("after midrst", 16'd1);

    // Start pulses while busy and in FINISH are ignored
    do_reset();
    snap_done = done_seen[0];
    snap_walk = walk_seen[0];
    run_gen(1'b1);
    repeat (30) @(negedge clk);
    check("ignored starts done pulses", 64'(done_seen[0] - snap_done), 64'd1);
    check("ignored starts walk_en", 64'(walk_seen[0] - snap_walk), 64'd64);
    check("ignored starts busy", 64'(busy), 64'd0);
    check_count("ignored starts", 16'd1);

    // Counter wrap
    @(negedge clk);
    force g_dut[0].u_dut.gen_count_q = 16'hFFFF;
    force g_dut[1].u_dut.gen_count_q = 16'hFFFF;
    @(negedge clk);
    release g_dut[0].u_dut.gen_count_q;
    release g_dut[1].u_dut.gen_count_q;
    @(negedge clk);
    check_count("preload", 16'hFFFF);
    predict();
    run_gen(1'b0);
    check_count("wrap", 16'h0000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
